// File: rtl/dff_reg_pkg.sv
// Shared constants and types for the dff_reg storage register family.
// Width limit, default reset/clear bit values, the control bundle and a width check.
package dff_reg_pkg;

  localparam int DFF_MAX_WIDTH = 64;

  localparam logic DFF_RESET_BIT = 1'b0;
  localparam logic DFF_CLEAR_BIT = 1'b0;

  typedef struct packed {
    logic en;
    logic clr;
  } dff_ctrl_t;

  function automatic bit dff_width_ok(input int width);
    return (width >= 1) && (width <= DFF_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/dff_cell.sv
// dff_cell: single storage bit with async active-high reset, sync clear and clock enable.
// Latency: one clk from d to q; reset acts immediately.
// No flow control: holds its value whenever en and clr are both low.
module dff_cell
  import dff_reg_pkg::*;
#(
  parameter logic RESET_VAL = DFF_RESET_BIT,
  parameter logic CLEAR_VAL = DFF_CLEAR_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic q
);

  // Priority: rst > clr > en; clear wins even when en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= CLEAR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_reg.sv
// dff_reg: WIDTH-bit D register (1..64) with clock enable, sync clear, async active-high reset.
// Latency: one clk from d to q; reset forces RESET_VALUE immediately, no d-to-q combinational path.
// No flow control; define DFF_REG_QN_EN to add qn, the complement of q taken from the same flops.
module dff_reg
  import dff_reg_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_RESET_BIT}},
  parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{DFF_CLEAR_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef DFF_REG_QN_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  dff_ctrl_t ctrl;
  assign ctrl = '{en: en, clr: clr};

  if (!dff_width_ok(WIDTH)) begin : g_width_chk
    $error("dff_reg: WIDTH=%0d outside legal range 1..%0d", WIDTH, DFF_MAX_WIDTH);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_cell #(
      .RESET_VAL (RESET_VALUE[i]),
      .CLEAR_VAL (CLEAR_VALUE[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (ctrl.en),
      .clr (ctrl.clr),
      .d   (d[i]),
      .q   (q[i])
    );
  end

`ifdef DFF_REG_QN_EN
  // Inverting the flop outputs keeps qn locked to q in every cycle, reset included.
  assign qn = ~q;
`endif

endmodule

// File: tb/tb_dff_reg.sv
// Self-checking bench for dff_reg: timed 1-bit waveform, reset/glitch corners, 8-bit vector table, random run.
`timescale 1ns/1ps
module tb_dff_reg;

  logic       clk = 1'b0;
  logic       rst1, en1, clr1, d1;
  logic       q1;
  logic       rst8, en8, clr8;
  logic [7:0] d8, q8;
`ifdef DFF_REG_QN_EN
  logic       q1n;
  logic [7:0] q8n;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] RV8 = 8'hA5;
  localparam logic [7:0] CV8 = 8'h0F;

  always #5 clk = ~clk;

  dff_reg u_dut1 (
    .clk (clk),
    .rst (rst1),
    .en  (en1),
    .clr (clr1),
    .d   (d1),
    .q   (q1)
`ifdef DFF_REG_QN_EN
    ,
    .qn  (q1n)
`endif
  );

  dff_reg #(
    .WIDTH       (8),
    .RESET_VALUE (RV8),
    .CLEAR_VALUE (CV8)
  ) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .en  (en8),
    .clr (clr8),
    .d   (d8),
    .q   (q8)
`ifdef DFF_REG_QN_EN
    ,
    .qn  (q8n)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic exp);
    chk(name, {7'b0, q1}, {7'b0, exp});
`ifdef DFF_REG_QN_EN
    chk({name, "_qn"}, {7'b0, q1n}, {7'b0, ~exp});
`endif
  endtask

  task automatic chk8(input string name, input logic [7:0] exp);
    chk(name, q8, exp);
`ifdef DFF_REG_QN_EN
    chk({name, "_qn"}, q8n, ~exp);
`endif
  endtask

  task automatic wait_until(input int t);
    if ($time < t) #(t - $time);
  endtask

  // Timed checks for the 1-bit waveform; times sit clear of the rising edges at 5,15,...
  typedef struct {
    int   t;
    logic exp;
  } tchk_t;

  // Per-cycle vectors for the 8-bit instance: inputs applied at negedge, q checked after the edge.
  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  initial begin
    tchk_t wave [12];
    vec_t  vecs [10];
    logic [7:0] model;
    logic       r_rst, r_en, r_clr;
    logic [7:0] r_d;

    wave = '{'{1, 1'b0},   '{50, 1'b0},  '{104, 1'b0}, '{106, 1'b1},
             '{114, 1'b1}, '{116, 1'b0}, '{164, 1'b0}, '{166, 1'b1},
             '{250, 1'b1}, '{314, 1'b1}, '{316, 1'b0}, '{330, 1'b0}};

    vecs = '{'{1'b1, 1'b0, 1'b0, 8'h00, RV8},
             '{1'b0, 1'b0, 1'b0, 8'h3C, RV8},
             '{1'b0, 1'b0, 1'b0, 8'h3C, RV8},
             '{1'b0, 1'b0, 1'b0, 8'h3C, RV8},
             '{1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C},
             '{1'b0, 1'b1, 1'b1, 8'hFF, CV8},
             '{1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A},
             '{1'b1, 1'b1, 1'b1, 8'hFF, RV8},
             '{1'b0, 1'b0, 1'b0, 8'h77, RV8},
             '{1'b0, 1'b1, 1'b0, 8'hC3, 8'hC3}};

    rst1 = 1'b1; en1 = 1'b1; clr1 = 1'b0; d1 = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; clr8 = 1'b0; d8 = 8'h00;

    // 1-bit waveform: d=1 for 100..110, then 160..310
    fork
      begin
        #2   rst1 = 1'b0;
        #98  d1 = 1'b1;
        #10  d1 = 1'b0;
        #50  d1 = 1'b1;
        #150 d1 = 1'b0;
      end
    join_none
    foreach (wave[i]) begin
      wait_until(wave[i].t);
      chk1($sformatf("wave%0d", i), wave[i].exp);
    end

    // Mid-cycle reset, release coincident with the edge at 445
    wait_until(400); d1 = 1'b1;
    wait_until(410); chk1("pre_rst_q1", 1'b1);
    wait_until(437); rst1 = 1'b1;
    wait_until(438); chk1("async_rst", 1'b0);
    // Nonblocking so the edge at 445 still sees rst high, as a release racing the edge must
    wait_until(445); rst1 <= 1'b0;
    wait_until(446); chk1("rel_edge_no_cap", 1'b0);
    wait_until(454); chk1("rel_hold", 1'b0);
    wait_until(456); chk1("rel_next_cap", 1'b1);

    // 3 ns glitch on d between edges is ignored
    wait_until(460); d1 = 1'b0;
    wait_until(466); chk1("glitch_pre", 1'b0);
    wait_until(467); d1 = 1'b1;
    wait_until(470); d1 = 1'b0;
    wait_until(476); chk1("glitch_edge1", 1'b0);
    wait_until(486); chk1("glitch_edge2", 1'b0);

    // 8-bit vector table
    chk8("rst8_hold", RV8);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst8 = vecs[i].rst; en8 = vecs[i].en; clr8 = vecs[i].clr; d8 = vecs[i].d;
      @(posedge clk);
      #1 chk8($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Random run against the priority rules
    model = vecs[9].exp;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      r_rst = ($urandom_range(15) == 0);
      r_clr = ($urandom_range(7) == 0);
      r_en  = $urandom_range(1) == 1;
      r_d   = 8'($urandom);
      rst8 = r_rst; en8 = r_en; clr8 = r_clr; d8 = r_d;
      if (r_rst) begin
        model = RV8;
        #1 chk8("rand_async", model);
      end
      @(posedge clk);
      if (r_rst)      model = RV8;
      else if (r_clr) model = CV8;
      else if (r_en)  model = r_d;
      #1 chk8($sformatf("rand%0d", n), model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
